// File: rtl/quant_4x4.sv
// quant_4x4 -- serial H.264-style quantizer for one 4x4 block of
// forward-transformed coefficients.
//
// A block is accepted on in_valid && in_ready. The 16 coefficients and the
// QP controls are captured on that edge. One coefficient per cycle then goes
// through a single shared multiplier, so Z[k] is written on accept edge + 1 + k.
// The finished block is presented with out_valid until out_ready is seen.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in DONE
// and stays high, with quantized stable, until out_ready is sampled high.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid / in_ready input block handshake
//   coeffs[16]          signed coefficients W[0..15], raster order
//   QP_BY_6, QP_MOD_6   QP/6 (clamped to 8) and QP%6 (6 and 7 read as 0)
//   intra               1 = intra rounding offset, 0 = inter rounding offset
//   out_valid/out_ready output block handshake
//   quantized[16]       signed levels Z[0..15]
//   nz_count            number of nonzero Z (only with QUANT_NZ_COUNT_EN)
//   state_dbg           current FSM state (0 IDLE, 1 QUANT, 2 DONE)
//
// Optional feature: define QUANT_NZ_COUNT_EN to add the nz_count output.
module quant_4x4 #(
   parameter int BIT_LENGTH = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [BIT_LENGTH:0] coeffs [16],
   input  logic [3:0]             QP_BY_6,
   input  logic [2:0]             QP_MOD_6,
   input  logic                   intra,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [BIT_LENGTH:0] quantized [16],
`ifdef QUANT_NZ_COUNT_EN
   output logic [4:0]             nz_count,
`endif
   output logic [1:0]             state_dbg
);

   localparam int CW  = BIT_LENGTH + 1;
   localparam int MFW = 14;
   // Sum width: product plus rounding offset, never narrower than 32 bits.
   localparam int SW  = (CW + MFW + 1 > 32) ? CW + MFW + 1 : 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] idx;

   // Block captured at accept
   logic signed [BIT_LENGTH:0] coef_r [16];
   logic [3:0] by6_r;
   logic [2:0] mod6_r;
   logic       intra_r;

   logic accept;
   logic handoff;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_dbg = state;
   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;

   // Multiplication factor by position class (0 = A, 1 = B, 2 = C) and QP%6.
   function automatic logic [MFW-1:0] mf_lookup(input logic [1:0] cls, input logic [2:0] m);
      logic [MFW-1:0] v;
      v = 14'd0;
      case (cls)
         2'd0: case (m)
            3'd0: v = 14'd13107; 3'd1: v = 14'd11916; 3'd2: v = 14'd10082;
            3'd3: v = 14'd9362;  3'd4: v = 14'd8192;  default: v = 14'd7282;
         endcase
         2'd1: case (m)
            3'd0: v = 14'd5243;  3'd1: v = 14'd4660;  3'd2: v = 14'd4194;
            3'd3: v = 14'd3647;  3'd4: v = 14'd3355;  default: v = 14'd2893;
         endcase
         default: case (m)
            3'd0: v = 14'd8066;  3'd1: v = 14'd7490;  3'd2: v = 14'd6554;
            3'd3: v = 14'd5825;  3'd4: v = 14'd5243;  default: v = 14'd4559;
         endcase
      endcase
      return v;
   endfunction

   // floor(2^(15+b)/3) for b = 0..8. The inter offset floor(2^q/6) equals
   // this value shifted right by one, so only one table is kept.
   function automatic logic [21:0] f_intra(input logic [3:0] b);
      logic [21:0] v;
      case (b)
         4'd0: v = 22'd10922;
         4'd1: v = 22'd21845;
         4'd2: v = 22'd43690;
         4'd3: v = 22'd87381;
         4'd4: v = 22'd174762;
         4'd5: v = 22'd349525;
         4'd6: v = 22'd699050;
         4'd7: v = 22'd1398101;
         default: v = 22'd2796202;
      endcase
      return v;
   endfunction

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = QUANT;
         QUANT:   if (idx == 4'd15) state_nxt = DONE;
         DONE:    if (handoff) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- shared datapath ----------------
   logic [BIT_LENGTH:0] cur_raw;
   logic                cur_neg;
   logic [BIT_LENGTH:0] abs_w;
   logic [1:0]          cls;
   logic [MFW-1:0]      mf;
   logic [21:0]         f_base;
   logic [21:0]         f_sel;
   logic [4:0]          qbits;
   logic [SW-1:0]       prod;
   logic [SW-1:0]       sum;
   logic [SW-1:0]       mag_full;
   logic [BIT_LENGTH:0] mag;
   logic [BIT_LENGTH:0] z_bits;
   logic                z_nonzero;
   logic                unused_mag_hi;

   always_comb begin
      cur_raw = coef_r[idx];
      cur_neg = cur_raw[BIT_LENGTH];
      // Two's complement negate as unsigned: the most negative input
      // becomes exactly 2^BIT_LENGTH.
      abs_w   = cur_neg ? (~cur_raw + CW'(1)) : cur_raw;
      // Positions {0,2,8,10} have idx[0]=idx[2]=0; {5,7,13,15} have both set.
      if (!idx[0] && !idx[2])     cls = 2'd0;
      else if (idx[0] && idx[2])  cls = 2'd1;
      else                        cls = 2'd2;
      mf        = mf_lookup(cls, mod6_r);
      f_base    = f_intra(by6_r);
      f_sel     = intra_r ? f_base : (f_base >> 1);
      qbits     = 5'd15 + {1'b0, by6_r};
      prod      = SW'(abs_w) * SW'(mf);
      sum       = prod + SW'(f_sel);
      mag_full  = sum >> qbits;
      mag       = mag_full[BIT_LENGTH:0];
      z_bits    = cur_neg ? (~mag + CW'(1)) : mag;
      z_nonzero = (mag != '0);
   end

   assign unused_mag_hi = ^mag_full[SW-1:CW];

   // ---------------- capture registers ----------------
   always_ff @(posedge clk) begin
      if (accept) begin
         coef_r  <= coeffs;
         by6_r   <= (QP_BY_6 > 4'd8) ? 4'd8 : QP_BY_6;
         mod6_r  <= (QP_MOD_6 > 3'd5) ? 3'd0 : QP_MOD_6;
         intra_r <= intra;
      end
   end

   // ---------------- state, index, results ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= 4'd0;
         for (int i = 0; i < 16; i++) quantized[i] <= '0;
`ifdef QUANT_NZ_COUNT_EN
         nz_count <= 5'd0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            idx <= 4'd0;
`ifdef QUANT_NZ_COUNT_EN
            nz_count <= 5'd0;
`endif
         end else if (state == QUANT) begin
            quantized[idx] <= $signed(z_bits);
            idx            <= idx + 4'd1;   // wraps to 0 after index 15
`ifdef QUANT_NZ_COUNT_EN
            nz_count       <= nz_count + {4'd0, z_nonzero};
`endif
         end
      end
   end

endmodule

// File: tb/tb_quant_4x4.sv
module tb_quant_4x4;

  localparam int BL = 15;
  localparam int W  = 16 * (BL + 1);

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic signed [BL:0] coeffs [16];
  logic [3:0] qp_by_6;
  logic [2:0] qp_mod_6;
  logic intra;
  logic out_valid;
  logic out_ready;
  logic signed [BL:0] quantized [16];
  logic [1:0] state_dbg;
`ifdef QUANT_NZ_COUNT_EN
  logic [4:0] nz_count;
`endif

  quant_4x4 #(.BIT_LENGTH(BL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .coeffs(coeffs), .QP_BY_6(qp_by_6), .QP_MOD_6(qp_mod_6), .intra(intra),
    .out_valid(out_valid), .out_ready(out_ready), .quantized(quantized),
`ifdef QUANT_NZ_COUNT_EN
    .nz_count(nz_count),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           nz_q[$];
  longint       acc_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic rand_ready = 1'b0;
  logic signed [BL:0] stim_w [16];

  // ---------------- reference model ----------------
  int mf_a[6] = '{13107, 11916, 10082, 9362, 8192, 7282};
  int mf_b[6] = '{5243, 4660, 4194, 3647, 3355, 2893};
  int mf_c[6] = '{8066, 7490, 6554, 5825, 5243, 4559};

  function automatic int model_z(int w, int k, int by, int md, bit it);
    int b2, m2, q, mf;
    longint mag, p, z;
    b2 = (by > 8) ? 8 : by;
    m2 = (md > 5) ? 0 : md;
    q  = 15 + b2;
    mag = (w < 0) ? -longint'(w) : longint'(w);
    if (k inside {0, 2, 8, 10})       mf = mf_a[m2];
    else if (k inside {5, 7, 13, 15}) mf = mf_b[m2];
    else                              mf = mf_c[m2];
    p = mag * mf + (longint'(1) << q) / (it ? 3 : 6);
    z = p >> q;
    return (w < 0) ? -int'(z) : int'(z);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_block(input int by, input int md, input bit it);
    logic [W-1:0] e;
    int nz, z, waited;
    waited = 0;
    @(posedge clk); #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
    for (int i = 0; i < 16; i++) coeffs[i] = stim_w[i];
    qp_by_6 = 4'(by); qp_mod_6 = 3'(md); intra = it;
    in_valid = 1'b1;
    @(posedge clk);
    e = '0; nz = 0;
    for (int k = 0; k < 16; k++) begin
      z = model_z(int'(stim_w[k]), k, by, md, it);
      e[k*16 +: 16] = 16'(z);
      if (z != 0) nz++;
    end
    exp_q.push_back(e);
    nz_q.push_back(nz);
    acc_q.push_back(longint'($time));
    #1;
    in_valid = 1'b0;
    // Scramble inputs: the block in flight must not see these.
    for (int i = 0; i < 16; i++) coeffs[i] = 16'($urandom);
    qp_by_6 = 4'($urandom); qp_mod_6 = 3'($urandom); intra = 1'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!out_valid) begin
      n_errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic release_block();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic check_z(string name, int k, int req);
    n_checks++;
    if (int'(quantized[k]) != req) begin
      n_errors++;
      $display("FAIL %s: Z[%0d]=%0d required %0d", name, k, quantized[k], req);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 16; i++) stim_w[i] = '0;
  endtask

  task automatic rand_stim(int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0: stim_w[i] = 16'($urandom);
        1: stim_w[i] = 16'(int'($urandom_range(0, 600)) - 300);
        default: stim_w[i] = ($urandom_range(0, 3) == 0) ? 16'sh8000 : 16'(int'($urandom_range(0, 8000)) - 4000);
      endcase
    end
  endtask

  // ---------------- random downstream ready ----------------
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic   prev_valid = 1'b0;
  int     bad_k;
  longint t_acc;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) begin
          n_checks++;
          if (acc_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_valid: out_valid=1 required 0 (no block accepted)");
          end else begin
            t_acc = acc_q.pop_front();
            if (longint'($time) - t_acc != 165) begin
              n_errors++;
              $display("FAIL latency: out_valid seen %0d ns after accept, required 165", longint'($time) - t_acc);
            end
          end
        end
        n_checks++;
        if (in_ready) begin
          n_errors++;
          $display("FAIL in_ready_in_done: in_ready=1 required 0");
        end
        if (exp_q.size() != 0) begin
          bad_k = -1;
          for (int k = 0; k < 16; k++)
            if (quantized[k] !== exp_q[0][k*16 +: 16] && bad_k < 0) bad_k = k;
          n_checks++;
          if (bad_k >= 0) begin
            n_errors++;
            $display("FAIL block_data: Z[%0d]=%0d required %0d", bad_k, quantized[bad_k],
                     $signed(exp_q[0][bad_k*16 +: 16]));
          end
`ifdef QUANT_NZ_COUNT_EN
          n_checks++;
          if (int'(nz_count) != nz_q[0]) begin
            n_errors++;
            $display("FAIL nz_count: nz_count=%0d required %0d", nz_count, nz_q[0]);
          end
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(nz_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- main sequence ----------------
  int zeros_ok;
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    qp_by_6 = '0; qp_mod_6 = '0; intra = 1'b0;
    for (int i = 0; i < 16; i++) coeffs[i] = '0;
    clear_stim();

    // Reset state
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // All-zero block, random QP
    clear_stim();
    send_block($urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom));
    wait_valid();
    zeros_ok = 1;
    for (int k = 0; k < 16; k++) if (quantized[k] != 0) zeros_ok = 0;
    n_checks++;
    if (zeros_ok == 0) begin
      n_errors++;
      $display("FAIL all_zero: some Z nonzero, required all 0 (Z[0]=%0d)", quantized[0]);
    end
    release_block();

    // W[0] = +100 and -100, QP_BY_6=4, QP_MOD_6=4, intra
    clear_stim(); stim_w[0] = 16'sd100;
    send_block(4, 4, 1'b1);
    wait_valid(); check_z("pos100", 0, 1); release_block();
    stim_w[0] = -16'sd100;
    send_block(4, 4, 1'b1);
    wait_valid(); check_z("neg100", 0, -1); release_block();

    // W[5] = 1000, QP 0/0, inter; also hold out_ready low for 5 cycles in DONE
    clear_stim(); stim_w[5] = 16'sd1000;
    send_block(0, 0, 1'b0);
    wait_valid();
    check_z("w5_1000", 5, 160);
    check_z("w5_other", 4, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) coeffs[i] = 16'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    check_z("hold_stable", 5, 160);
    release_block();

    // Three nonzero levels
    clear_stim(); stim_w[0] = 16'sd1000; stim_w[5] = 16'sd1000; stim_w[15] = -16'sd1000;
    send_block(0, 0, 1'b0);
    wait_valid();
    check_z("nz3_z15", 15, -160);
`ifdef QUANT_NZ_COUNT_EN
    n_checks++;
    if (nz_count != 5'd3) begin
      n_errors++;
      $display("FAIL nz_three: nz_count=%0d required 3", nz_count);
    end
`endif
    release_block();

    // Reset while index = 7
    rand_stim(2);
    send_block(2, 1, 1'b1);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    zeros_ok = 1;
    for (int k = 0; k < 16; k++) if (quantized[k] != 0) zeros_ok = 0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || zeros_ok == 0) begin
      n_errors++;
      $display("FAIL reset_midblock: out_valid=%0b in_ready=%0b zeros=%0d required 0 1 1",
               out_valid, in_ready, zeros_ok);
    end
    exp_q.delete(); nz_q.delete(); acc_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_reset: in_ready=%0b required 1", in_ready);
    end
    rand_stim(1);
    send_block(1, 3, 1'b0);
    wait_valid();
    release_block();

    // Randomized blocks with random downstream backpressure
    rand_ready = 1'b1;
    for (int b = 0; b < 24; b++) begin
      rand_stim(b % 3);
      send_block($urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom));
    end
    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL drain: %0d blocks outstanding, required 0", exp_q.size());
      end
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
